// File: rtl/bcd_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_event_counter
//  Description : Synchronous cascade of DIGITS modulo-RADIX digits that counts
//                falling edges of an asynchronous event input. Supports
//                up/down counting, count enable, synchronous parallel load with
//                illegal-digit flagging, a registered whole-counter
//                carry/borrow pulse and a combinational terminal-count flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   system clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    x         in   asynchronous event input, one count per falling edge
//    en        in   count enable, events seen while low are discarded
//    up        in   direction, 1 = increment, 0 = decrement
//    load      in   synchronous parallel load strobe (highest priority)
//    din       in   load value, digit i at din[i*W +: W], digit 0 is LSD
//    q         out  current count, same packing as din
//    z         out  registered one-clock carry/borrow pulse on full wrap
//    tc        out  terminal count for the current direction (combinational)
//    load_err  out  registered one-clock pulse, din held a digit >= RADIX
// ============================================================================
module bcd_event_counter #(
  parameter  int DIGITS = 2,
  parameter  int RADIX  = 10,
  localparam int W      = $clog2(RADIX)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                x,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] din,
  output logic [DIGITS*W-1:0] q,
  output logic                z,
  output logic                tc,
  output logic                load_err
);

  localparam logic [W-1:0] C_MAX  = W'(RADIX - 1);
  localparam logic [W-1:0] C_ZERO = '0;
  localparam logic [W-1:0] C_ONE  = W'(1);

  // --------------------------------------------------------------------------
  // Event input path: two-flop synchroniser plus a delay flop for edge
  // detection. All three reset to 0 so a high x at reset release is seen as a
  // rising edge (ignored), never as a false falling edge.
  // --------------------------------------------------------------------------
  logic r_xs1;
  logic r_xs2;
  logic r_xd;
  logic w_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs1 <= 1'b0;
      r_xs2 <= 1'b0;
      r_xd  <= 1'b0;
    end else begin
      r_xs1 <= x;
      r_xs2 <= r_xs1;
      r_xd  <= r_xs2;
    end
  end

  assign w_ev = r_xd & ~r_xs2;

  // --------------------------------------------------------------------------
  // Per-digit decode and next-value generation.
  // --------------------------------------------------------------------------
  logic [DIGITS*W-1:0] r_q;
  logic [DIGITS*W-1:0] w_cnt_q;    // count result in the current direction
  logic [DIGITS*W-1:0] w_load_q;   // din with illegal digits forced to 0
  logic [DIGITS-1:0]   w_is_max;
  logic [DIGITS-1:0]   w_is_zero;
  logic [DIGITS-1:0]   w_lo_max;   // all digits below i are at RADIX-1
  logic [DIGITS-1:0]   w_lo_zero;  // all digits below i are at 0
  logic [DIGITS-1:0]   w_din_bad;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [W-1:0] w_dig;
      logic [W-1:0] w_din_dig;
      logic [W-1:0] w_inc;
      logic [W-1:0] w_dec;

      assign w_dig     = r_q[gi*W +: W];
      assign w_din_dig = din[gi*W +: W];

      assign w_is_max[gi]  = (w_dig == C_MAX);
      assign w_is_zero[gi] = (w_dig == C_ZERO);

      // Each wrap is explicit so a value outside 0..RADIX-1 is never formed,
      // even when RADIX is not a power of two.
      assign w_inc = w_is_max[gi]  ? C_ZERO : (w_dig + C_ONE);
      assign w_dec = w_is_zero[gi] ? C_MAX  : (w_dig - C_ONE);

      // Ripple-free enable: each digit looks at all lower digits directly
      // rather than chaining through its neighbour's enable.
      if (gi == 0) begin : g_lsd
        assign w_lo_max[gi]  = 1'b1;
        assign w_lo_zero[gi] = 1'b1;
      end else begin : g_upper
        assign w_lo_max[gi]  = &w_is_max[gi-1:0];
        assign w_lo_zero[gi] = &w_is_zero[gi-1:0];
      end

      always_comb begin
        w_cnt_q[gi*W +: W] = w_dig;
        if (up) begin
          if (w_lo_max[gi]) begin
            w_cnt_q[gi*W +: W] = w_inc;
          end
        end else begin
          if (w_lo_zero[gi]) begin
            w_cnt_q[gi*W +: W] = w_dec;
          end
        end
      end

      assign w_din_bad[gi]       = (w_din_dig > C_MAX);
      assign w_load_q[gi*W +: W] = w_din_bad[gi] ? C_ZERO : w_din_dig;
    end
  endgenerate

  logic w_all_max;
  logic w_all_zero;
  logic w_count;
  logic w_wrap;

  assign w_all_max  = &w_is_max;
  assign w_all_zero = &w_is_zero;

  // Load wins over a coincident event, which is then dropped.
  assign w_count = w_ev & en & ~load;

  // Whole-counter wrap on this edge in the direction being sampled now.
  assign w_wrap  = w_count & (up ? w_all_max : w_all_zero);

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_q;
    end else if (w_count) begin
      r_q <= w_cnt_q;
    end
  end

  logic r_z;
  logic r_load_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z        <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_z        <= w_wrap;
      r_load_err <= load & (|w_din_bad);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs.
  // --------------------------------------------------------------------------
  assign q        = r_q;
  assign z        = r_z;
  assign load_err = r_load_err;
  assign tc       = up ? w_all_max : w_all_zero;

endmodule
`default_nettype wire

// File: tb/tb_bcd_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_event_counter
//  Description : Self-checking bench for bcd_event_counter. Two instances
//                (2 x mod-10 and 2 x mod-6) share the control inputs; each is
//                tracked by an integer reference model of the count value.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_event_counter;

  localparam int R10 = 10;
  localparam int R6  = 6;
  localparam int W10 = 4;
  localparam int W6  = 3;
  localparam int ND  = 2;
  localparam int M10 = R10 * R10;
  localparam int M6  = R6 * R6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x = 1'b1;
  logic       en = 1'b1;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] din10 = '0;
  logic [5:0] din6 = '0;
  logic [7:0] q10;
  logic [5:0] q6;
  logic       z10, z6, tc10, tc6, le10, le6;

  int total = 0;
  int bad   = 0;
  int m10   = 0;   // reference count value of the mod-10 instance
  int m6    = 0;   // reference count value of the mod-6 instance

  always #5 clk = ~clk;

  bcd_event_counter #(.DIGITS(ND), .RADIX(R10)) dut10 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .up(up), .load(load),
    .din(din10), .q(q10), .z(z10), .tc(tc10), .load_err(le10)
  );

  bcd_event_counter #(.DIGITS(ND), .RADIX(R6)) dut6 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .up(up), .load(load),
    .din(din6), .q(q6), .z(z6), .tc(tc6), .load_err(le6)
  );

  // ---------------- reference model helpers ----------------
  function automatic int to_q(int v, int radix, int w);
    int r = 0;
    for (int i = 0; i < ND; i++) begin
      r = r | ((v % radix) << (i * w));
      v = v / radix;
    end
    return r;
  endfunction

  function automatic int from_din(int d, int radix, int w, output bit err);
    int v = 0;
    int mult = 1;
    err = 1'b0;
    for (int i = 0; i < ND; i++) begin
      int dig;
      dig = (d >> (i * w)) & ((1 << w) - 1);
      if (dig >= radix) begin
        err = 1'b1;
        dig = 0;
      end
      v = v + dig * mult;
      mult = mult * radix;
    end
    return v;
  endfunction

  function automatic int step(int v, int m, bit dir_up, output bit wrap);
    if (dir_up) begin
      wrap = (v == m - 1);
      return (v + 1) % m;
    end
    wrap = (v == 0);
    return (v == 0) ? m - 1 : v - 1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_q10"},  int'(q10),  to_q(m10, R10, W10));
    chk({tag, "_q6"},   int'(q6),   to_q(m6, R6, W6));
    chk({tag, "_tc10"}, int'(tc10), int'(up ? (m10 == M10 - 1) : (m10 == 0)));
    chk({tag, "_tc6"},  int'(tc6),  int'(up ? (m6 == M6 - 1) : (m6 == 0)));
  endtask

  // One falling edge on x, held long enough to be seen, then released.
  // Counts z-high samples so both presence and one-cycle width are checked.
  task automatic do_event(input string tag);
    int zc10 = 0;
    int zc6  = 0;
    bit w10 = 1'b0;
    bit w6  = 1'b0;
    x = 1'b0;
    repeat (4) begin tick(); zc10 += int'(z10); zc6 += int'(z6); end
    x = 1'b1;
    repeat (4) begin tick(); zc10 += int'(z10); zc6 += int'(z6); end
    if (en) begin
      m10 = step(m10, M10, up, w10);
      m6  = step(m6, M6, up, w6);
    end
    chk_state(tag);
    chk({tag, "_z10"}, zc10, int'(w10));
    chk({tag, "_z6"},  zc6,  int'(w6));
  endtask

  task automatic do_load(input string tag, input logic [7:0] d10, input logic [5:0] d6);
    bit e10, e6;
    din10 = d10;
    din6  = d6;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    m10 = from_din(int'(d10), R10, W10, e10);
    m6  = from_din(int'(d6), R6, W6, e6);
    chk_state(tag);
    chk({tag, "_le10"}, int'(le10), int'(e10));
    chk({tag, "_le6"},  int'(le6),  int'(e6));
    chk({tag, "_z10"},  int'(z10),  0);
    tick();
    chk({tag, "_le10_off"}, int'(le10), 0);
    chk({tag, "_le6_off"},  int'(le6),  0);
  endtask

  initial begin
    // ---- reset ----
    repeat (3) tick();
    chk_state("rst");
    chk("rst_z10", int'(z10), 0);
    chk("rst_le10", int'(le10), 0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk_state("rst_rel");

    // ---- first event latency: q changes exactly at E2 ----
    x = 1'b0;
    tick();  // E0
    chk("lat_e0", int'(q10), 0);
    tick();  // E1
    chk("lat_e1", int'(q10), 0);
    tick();  // E2
    chk("lat_e2", int'(q10), 8'h01);
    x = 1'b1;
    repeat (4) tick();
    m10 = 1;
    m6  = 1;
    for (int i = 0; i < 9; i++) do_event("cnt");
    chk("cnt10_final", int'(q10), 8'h10);

    // ---- up wrap ----
    do_load("ld98", 8'h98, {3'd5, 3'd4});
    do_event("upw1");
    chk("upw1_tc", int'(tc10), 1);
    do_event("upw2");

    // ---- down wrap ----
    up = 1'b0;
    do_load("ld01", 8'h01, {3'd0, 3'd1});
    do_event("dnw1");
    do_event("dnw2");
    chk("dnw2_q", int'(q10), 8'h99);

    // ---- illegal load colliding with an event ----
    up = 1'b1;
    x = 1'b0;
    tick();  // E0
    tick();  // E1, event now pending for the next edge
    begin
      bit e10, e6;
      din10 = 8'hA7;
      din6  = {3'd7, 3'd2};
      load  = 1'b1;
      tick();
      load  = 1'b0;
      m10 = from_din(int'(din10), R10, W10, e10);
      m6  = from_din(int'(din6), R6, W6, e6);
      chk("col_q10", int'(q10), 8'h07);
      chk("col_le10", int'(le10), 1);
      chk("col_le6", int'(le6), 1);
      chk_state("col");
    end
    tick();
    chk("col_hold_q10", int'(q10), 8'h07);
    chk("col_le_off", int'(le10), 0);
    x = 1'b1;
    repeat (4) tick();
    chk_state("col_after");
    en = 1'b0;
    for (int i = 0; i < 5; i++) do_event("dis");
    chk("dis_q10", int'(q10), 8'h07);
    en = 1'b1;

    // ---- radix 6 ----
    do_load("ld55", 8'h12, {3'd5, 3'd5});
    do_event("r6a");
    chk("r6a_q6", int'(q6), 0);
    do_load("ld05", 8'h34, {3'd0, 3'd5});
    do_event("r6b");
    chk("r6b_q6", int'(q6), {3'd1, 3'd0});

    // ---- reset in the middle of an event ----
    do_load("ld_pre", 8'h42, {3'd2, 3'd3});
    x = 1'b0;
    tick();  // E0
    tick();  // E1
    rst_n = 1'b0;
    #1;
    m10 = 0;
    m6  = 0;
    chk("mrst_async_q10", int'(q10), 0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk("mrst_z10", int'(z10), 0);
    end
    chk_state("mrst");
    x = 1'b1;
    repeat (4) tick();
    chk_state("mrst_rel");

    // ---- randomized operations ----
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_load("rnd_ld", 8'($urandom), 6'($urandom));
      end else begin
        en = 1'($urandom_range(0, 4) != 0);
        up = 1'($urandom);
        do_event("rnd_ev");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against any unexpected stall.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
